load_store_unit: RTL and testbench

- Sits between the core's execute stage and the word-addressed data memory port (combinational read, write on clock edge, word-only writes).
- Turns core byte/halfword/word load and store requests into memory accesses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Misaligned requests are rejected with an error response and never touch memory.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_if.sv | 43 ++++
 rtl/lsu_lane_align.sv | 43 ++++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int XLEN = 32;

    // Access size encodings carried on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // The one size encoding that no instruction produces.
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // A request is rejected when its size is illegal or its address is not
    // a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE:    bad = 1'b0;
            SZ_HALF:    bad = off[0];
            SZ_WORD:    bad = (off != 2'b00);
            SZ_ILLEGAL: bad = 1'b1;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response handshake plus the word-addressed memory port.
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the core keeps its request fields stable while
// req_valid is high and not yet accepted. A response transfers on a rising
// edge where resp_valid and resp_ready are both 1; resp_rdata and resp_err
// hold steady from the rise of resp_valid until that edge. Memory reads are
// combinational (mem_rd follows mem_ra in the same cycle) and a write is
// committed on the rising edge at the end of a cycle with mem_we high.
interface lsu_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic [XLEN-1:0] mem_ra;
    logic [XLEN-1:0] mem_rd;
    logic            mem_we;
    logic [XLEN-1:0] mem_wa;
    logic [XLEN-1:0] mem_wd;

    // The load/store unit's view.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_ra, mem_we, mem_wa, mem_wd
    );

    // The core and memory view.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_ra, mem_we, mem_wa, mem_wd
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a memory word and right-aligned core data:
// the load path picks and extends a lane, the store path merges a lane in.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ext,
    output logic [XLEN-1:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word[{offset, 3'b000} +: 8];
    assign half_lane = word[{offset[1], 4'b0000} +: 16];

    // Load path: select the addressed lane and sign- or zero-extend it.
    always_comb begin
        ext = word;
        case (size)
            SZ_BYTE: ext = {{(XLEN-8){~is_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: ext = {{(XLEN-16){~is_unsigned & half_lane[15]}}, half_lane};
            default: ext = word;
        endcase
    end

    // Store path: replace only the addressed lane of the old word.
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8]    = wdata[7:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, sub-word stores by
// read-modify-write, misaligned or illegal requests answered with an error
// without touching memory. All handshake and memory outputs are registered.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_if.slave       bus,
    output lsu_state_t dbg_state
);

    lsu_state_t      state;
    logic [XLEN-1:0] addr_q;
    logic [1:0]      size_q;
    logic            we_q;
    logic            uns_q;
    logic [XLEN-1:0] wdata_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            resp_err_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_wd_q;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] merged;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .word        (bus.mem_rd),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .ext         (ext),
        .merged      (merged)
    );

    // Memory addresses always point at the word holding the captured address.
    assign bus.mem_ra     = {addr_q[XLEN-1:2], 2'b00};
    assign bus.mem_wa     = {addr_q[XLEN-1:2], 2'b00};
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wd     = mem_wd_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign dbg_state      = state;

    // Controller: capture on accept, then READ and/or WRITE, then hold RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wd_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        addr_q      <= bus.req_addr;
                        size_q      <= bus.req_size;
                        we_q        <= bus.req_we;
                        uns_q       <= bus.req_unsigned;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_valid_q <= 1'b1;
                            state        <= ST_RESP;
                        end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                            // Full-word store needs no old data.
                            mem_we_q <= 1'b1;
                            mem_wd_q <= bus.req_wdata;
                            state    <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (we_q) begin
                        // Old word is on mem_rd now; latch the merged result.
                        mem_wd_q <= merged;
                        mem_we_q <= 1'b1;
                        state    <= ST_WRITE;
                    end else begin
                        resp_rdata_q <= ext;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    // The write commits on this edge; mem_we is a single pulse.
                    mem_we_q     <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        req_ready_q  <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory model,
// scoreboard queue filled at issue time, monitor comparing each response.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int EW = 109;
    // Expected entry layout:
    // [31:0] rdata, [32] err, [40:33] latency, [42:41] writes, [44:43] reads,
    // [76:45] write data, [108:77] write address
    logic [EW-1:0] exp_q[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if #(.XLEN(32)) bus();
    lsu_state_t dbg_state;

    load_store_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory (1 KiB, words 0x000..0x3FC) ----------------
    logic [31:0] mem_arr [0:255];
    logic        pre_clr = 1'b0;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_d = '0;

    assign bus.mem_rd = (bus.mem_ra < 32'h400) ? mem_arr[bus.mem_ra[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (pre_clr) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
        end else if (pre_we) begin
            mem_arr[pre_idx] <= pre_d;
        end else if (bus.mem_we && (bus.mem_wa < 32'h400)) begin
            mem_arr[bus.mem_wa[9:2]] <= bus.mem_wd;
        end
    end

    // ---------------- reference model: byte array ----------------
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (a < 32'h400 && ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 8'h00;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rd_byte(a + 32'(i));
        return w;
    endfunction

    task automatic preset_word(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = a[9:2];
        pre_d   = d;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    // ---------------- core-side driver ----------------
    logic hold_low = 1'b0;

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic ok);
        ok = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Compute the expected outcome from the access rules, update the model,
    // push the expectation, then issue the request.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int          nb;
        logic        err;
        logic [31:0] aligned;
        logic [31:0] rdata;
        logic [31:0] wd;
        logic [7:0]  lat;
        logic [1:0]  nwr;
        logic [1:0]  nrd;
        longint      v;
        logic        ok;
        nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err     = (size == 2'd3) || ((addr & 32'(nb - 1)) != 0);
        aligned = addr & 32'hFFFF_FFFC;
        rdata   = '0;
        wd      = '0;
        nwr     = 2'd0;
        nrd     = 2'd0;
        if (err) begin
            lat = 8'd1;
        end else if (!we) begin
            v = 0;
            for (int i = 0; i < nb; i++) v += longint'(rd_byte(addr + 32'(i))) << (8 * i);
            if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
            rdata = v[31:0];
            lat   = 8'd2;
            nrd   = 2'd1;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (aligned + 32'(j) >= addr && aligned + 32'(j) < addr + 32'(nb))
                    wd[8*j +: 8] = wdata[8*(int'(aligned) + j - int'(addr)) +: 8];
                else
                    wd[8*j +: 8] = rd_byte(aligned + 32'(j));
            end
            if (addr < 32'h400)
                for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            lat = (nb == 4) ? 8'd2 : 8'd3;
            nrd = (nb == 4) ? 2'd0 : 2'd1;
            nwr = 2'd1;
        end
        exp_q.push_back({aligned, wd, nrd, nwr, lat, err, rdata});
        drive(we, size, uns, addr, wdata, ok);
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 at %0t", $time);
            void'(exp_q.pop_back());
        end
    endtask

    // Response consumer: random back-pressure unless a hold is requested.
    always @(posedge clk) begin
        #1;
        bus.resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor / scoreboard ----------------
    int            cyc = 0;
    int            acc_cyc = 0;
    int            nrd_c = 0;
    int            nwr_c = 0;
    logic          in_resp = 1'b0;
    logic          outstanding = 1'b0;
    logic [31:0]   first_rdata;
    logic          first_err;
    logic [31:0]   last_wa;
    logic [31:0]   last_wd;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_resp     = 1'b0;
            outstanding = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                chk("accept_while_busy", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
                acc_cyc     = cyc;
                nrd_c       = 0;
                nwr_c       = 0;
            end else begin
                if (dbg_state == ST_READ) nrd_c++;
                if (bus.mem_we) begin
                    nwr_c++;
                    last_wa = bus.mem_wa;
                    last_wd = bus.mem_wd;
                end
            end
            if (bus.resp_valid) begin
                chk("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
                if (!in_resp) begin
                    in_resp     = 1'b1;
                    first_rdata = bus.resp_rdata;
                    first_err   = bus.resp_err;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_resp: got resp_valid=1 expected 0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", bus.resp_rdata, e[31:0]);
                        chk("resp_err", 32'(bus.resp_err), 32'(e[32]));
                        chk("latency", 32'(cyc - acc_cyc), 32'(e[40:33]));
                        chk("write_count", 32'(nwr_c), 32'(e[42:41]));
                        chk("read_cycles", 32'(nrd_c), 32'(e[44:43]));
                        if (e[42:41] == 2'd1) begin
                            chk("mem_wa", last_wa, e[108:77]);
                            chk("mem_wd", last_wd, e[76:45]);
                        end
                    end
                end else begin
                    chk("resp_rdata_stable", bus.resp_rdata, first_rdata);
                    chk("resp_err_stable", 32'(bus.resp_err), 32'(first_err));
                end
                if (bus.resp_ready) begin
                    in_resp     = 1'b0;
                    outstanding = 1'b0;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic ok;
        logic got;
        logic [31:0] a;
        logic [1:0]  sz;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b1;

        // Memory preset while held in reset.
        @(negedge clk);
        pre_clr = 1'b1;
        @(negedge clk);
        pre_clr = 1'b0;
        preset_word(32'h100, 32'h8844_22F1);
        preset_word(32'h200, 32'h0102_0304);

        // Reset values.
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_ra", bus.mem_ra, 32'd0);
        chk("rst_mem_wa", bus.mem_wa, 32'd0);
        chk("rst_mem_wd", bus.mem_wd, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loads from the preset word.
        do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h100, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);

        // Sub-word store by read-modify-write, then read back.
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h102, 32'h0000_00AB);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_CAFE);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);

        // Word store, then read back.
        do_req(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);

        // Misaligned and illegal requests.
        do_req(1'b0, 2'd1, 1'b0, 32'h101, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'h5555_5555);
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h103, 32'h7777);

        // Back-pressure: hold resp_ready low for 5 cycles with a request pending.
        hold_low = 1'b1;
        fork
            begin
                do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
                do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
            end
            begin
                got = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (bus.resp_valid) begin
                        got = 1'b1;
                        break;
                    end
                end
                chk("hold_resp_seen", 32'(got), 32'd1);
                repeat (5) @(posedge clk);
                #1;
                hold_low = 1'b0;
            end
        join

        // Reset during the WRITE cycle of a byte store.
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_resp && bus.req_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("idle_before_reset_test", 32'(got), 32'd1);
        drive(1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00EE, ok);
        chk("rst_test_accept", 32'(ok), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dbg_state == ST_WRITE) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_test_reached_write", 32'(got), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_we_drop", 32'(bus.mem_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_partial_write", mem_arr[8'h80], rd_word(32'h200));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);

        // Randomized traffic over a small window plus out-of-range addresses.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 15));
            else a = 32'h100 + 32'($urandom_range(0, 31));
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 2) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
        end

        // Drain outstanding responses.
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_resp) begin
                got = 1'b1;
                break;
            end
        end
        chk("drain", 32'(got), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
